data_mem_responder: RTL and testbench

//   Data-memory responder at the far end of the control path's data-memory request interface.
//   - Accepts one load/store request (read/write enable, address, funct3 format, store data).
//   - Inserts a programmable number of wait states.
//   - Returns a one-cycle ready pulse with load data sign/zero-extended per RV32I rules.
//   - Core stalls its pc write while a request is outstanding; multicycle/pipelined cores share it.

---
 rtl/data_mem_responder.sv | 213 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_STATES cycles, then pulses ready
// with RV32I-extended load data. Request inputs are ignored while busy; there is no queueing.
module data_mem_responder #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [31:0] address,
    input  logic [2:0]  data_format,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        busy,
    output logic        error
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [2:0]    fmt_q, fmt_d;
    logic [31:0]   wdat_q, wdat_d;
    logic          rd_q, rd_d, wr_q, wr_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          error_q, error_d;

    logic [31:0]   mem_q [MEM_WORDS];

    logic          unused_addr_bits;
    assign unused_addr_bits = ^address[31:AW+2];

    // With zero wait states the response is built from the live inputs on the accept edge.
    logic          cur_rd, cur_wr;
    logic [AW+1:0] cur_addr;
    logic [2:0]    cur_fmt;
    logic [31:0]   cur_wdat;

    always_comb begin
        cur_rd   = rd_q;
        cur_wr   = wr_q;
        cur_addr = addr_q;
        cur_fmt  = fmt_q;
        cur_wdat = wdat_q;
        if (state_q == S_IDLE) begin
            cur_rd   = read_enable;
            cur_wr   = write_enable;
            cur_addr = address[AW+1:0];
            cur_fmt  = data_format;
            cur_wdat = write_data;
        end
    end

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   rword, rshift, wshift, load_val, store_word;
    logic [3:0]    byte_en;
    logic          fmt_ok, align_ok, legal;

    assign word_idx = cur_addr[AW+1:2];
    assign lane     = cur_addr[1:0];
    assign rword    = mem_q[word_idx];
    assign rshift   = rword >> {lane, 3'b000};
    assign wshift   = cur_wdat << {lane, 3'b000};

    always_comb begin
        fmt_ok   = 1'b0;
        align_ok = 1'b1;
        load_val = 32'h0;
        byte_en  = 4'b0000;
        case (cur_fmt)
            3'b000: begin
                fmt_ok   = 1'b1;
                load_val = {{24{rshift[7]}}, rshift[7:0]};
                byte_en  = 4'b0001 << lane;
            end
            3'b001: begin
                fmt_ok   = 1'b1;
                load_val = {{16{rshift[15]}}, rshift[15:0]};
                byte_en  = 4'b0011 << lane;
            end
            3'b010: begin
                fmt_ok   = 1'b1;
                load_val = rword;
                byte_en  = 4'b1111;
            end
            3'b100: begin
                fmt_ok   = cur_rd;
                load_val = {24'h0, rshift[7:0]};
            end
            3'b101: begin
                fmt_ok   = cur_rd;
                load_val = {16'h0, rshift[15:0]};
            end
            default: fmt_ok = 1'b0;
        endcase
        case (cur_fmt[1:0])
            2'b01:   align_ok = ~lane[0];
            2'b10:   align_ok = (lane == 2'b00);
            default: align_ok = 1'b1;
        endcase
        legal = (cur_rd ^ cur_wr) & fmt_ok & align_ok;
    end

    always_comb begin
        store_word = rword;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                store_word[8*b +: 8] = wshift[8*b +: 8];
            end
        end
    end

    logic enter_resp;
    logic mem_we;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        fmt_d       = fmt_q;
        wdat_d      = wdat_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        read_data_d = 32'h0;
        ready_d     = 1'b0;
        error_d     = 1'b0;
        enter_resp  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (read_enable | write_enable) begin
                    addr_d = address[AW+1:0];
                    fmt_d  = data_format;
                    wdat_d = write_data;
                    rd_d   = read_enable;
                    wr_d   = write_enable;
                    if (WAIT_STATES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (enter_resp) begin
            ready_d     = 1'b1;
            error_d     = ~legal;
            read_data_d = (legal && cur_rd) ? load_val : 32'h0;
        end
        busy_d = (state_d != S_IDLE);
    end

    assign mem_we = enter_resp & legal & cur_wr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            fmt_q       <= 3'd0;
            wdat_q      <= 32'h0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            read_data_q <= 32'h0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            fmt_q       <= fmt_d;
            wdat_q      <= wdat_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    // Backing store is never cleared; reset only blocks a commit on the same edge.
    always_ff @(posedge clock) begin
        if (mem_we && reset_n) begin
            mem_q[word_idx] <= store_word;
        end
    end

    assign read_data = read_data_q;
    assign ready     = ready_q;
    assign busy      = busy_q;
    assign error     = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, multi-cycle corner sequences and
// randomized loads/stores against a byte-level memory model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en [2];
    logic        wr_en [2];
    logic [31:0] addr;
    logic [2:0]  fmt;
    logic [31:0] wdat;
    logic [31:0] rdata [2];
    logic        rdy [2];
    logic        bsy [2];
    logic        err [2];

    always #5 clk = ~clk;

    data_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(2)) dut0 (
        .clock(clk), .reset_n(rst_n), .read_enable(rd_en[0]), .write_enable(wr_en[0]),
        .address(addr), .data_format(fmt), .write_data(wdat),
        .read_data(rdata[0]), .ready(rdy[0]), .busy(bsy[0]), .error(err[0])
    );

    data_mem_responder #(.MEM_WORDS(16), .WAIT_STATES(0)) dut1 (
        .clock(clk), .reset_n(rst_n), .read_enable(rd_en[1]), .write_enable(wr_en[1]),
        .address(addr), .data_format(fmt), .write_data(wdat),
        .read_data(rdata[1]), .ready(rdy[1]), .busy(bsy[1]), .error(err[1])
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] model_mem [int];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [2:0]  f;
        logic [31:0] d;
        logic [31:0] exp_d;
        bit          exp_e;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [2:0] f, input logic [31:0] d,
                                input logic [31:0] exp_d, input bit exp_e);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.f = f; v.d = d; v.exp_d = exp_d; v.exp_e = exp_e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Model: access size in bytes, legality and byte-lane arithmetic from the RV32I rules.
    function automatic int msize(input logic [2:0] f);
        case (f[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit mlegal(input bit rd, input bit wr, input logic [31:0] a, input logic [2:0] f);
        if (rd == wr) return 1'b0;
        if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b0;
        if (wr && f >= 3'd4) return 1'b0;
        return (a % msize(f)) == 0;
    endfunction

    function automatic int midx(input logic [31:0] a, input int words);
        return int'((a / 4) % words);
    endfunction

    function automatic logic [31:0] mget(input int idx);
        if (model_mem.exists(idx)) return model_mem[idx];
        return 32'h0;
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] a, input logic [2:0] f, input int words);
        longint w, v, span;
        int sz;
        sz   = msize(f);
        w    = longint'(mget(midx(a, words)));
        span = 64'd1 << (8 * sz);
        v    = (w >> (8 * (a % 4))) % span;
        if (f < 3'd4 && sz < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic mstore(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d, input int words);
        logic [31:0] w;
        int ln;
        w = mget(midx(a, words));
        for (int i = 0; i < msize(f); i++) begin
            ln = int'(a % 4) + i;
            w[8*ln +: 8] = d[8*i +: 8];
        end
        model_mem[midx(a, words)] = w;
    endtask

    task automatic do_req(input int sel, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [2:0] f, input logic [31:0] d,
                          output logic [31:0] rd_out, output logic er_out, output int lat);
        @(negedge clk);
        rd_en[sel] = rd; wr_en[sel] = wr; addr = a; fmt = f; wdat = d;
        @(posedge clk);
        #1;
        rd_en[sel] = 1'b0; wr_en[sel] = 1'b0;
        lat = -1; rd_out = 32'h0; er_out = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (rdy[sel]) begin
                lat = n; rd_out = rdata[sel]; er_out = err[sel];
                break;
            end
        end
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL timeout sel=%0d actual=no-ready required=ready", sel);
        end
    endtask

    // Runs one request on the WAIT_STATES=2 instance and keeps the model in step.
    task automatic run_op(input bit rd, input bit wr, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] d, output logic [31:0] got_d, output logic got_e,
                          output int lat, output logic [31:0] mexp_d, output logic mexp_e);
        bit lg;
        lg     = mlegal(rd, wr, a, f);
        mexp_d = (lg && rd) ? mload(a, f, 1024) : 32'h0;
        mexp_e = !lg;
        do_req(0, rd, wr, a, f, d, got_d, got_e, lat);
        if (lg && wr) mstore(a, f, d, 1024);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gd, md;
        logic        ge, me;
        int          lat, extra;
        int          t [$];
        logic [31:0] a;
        logic [2:0]  f;
        bit          rd, wr;

        rd_en[0] = 0; wr_en[0] = 0; rd_en[1] = 0; wr_en[1] = 0;
        addr = 0; fmt = 0; wdat = 0;
        rst_n = 1'b0;
        #12;
        check("reset_outputs0", {rdata[0], 1'b0, rdy[0], bsy[0], err[0]}, 32'h0);
        check("reset_outputs1", {rdata[1], 1'b0, rdy[1], bsy[1], err[1]}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back(mk(0, 1, 32'h10,   3'd2, 32'hDEADBEEF, 32'h0,        0));
        tbl.push_back(mk(1, 0, 32'h10,   3'd2, 32'h0,        32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 1, 32'h10,   3'd2, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 1, 32'h13,   3'd0, 32'h12345680, 32'h0,        0));
        tbl.push_back(mk(1, 0, 32'h10,   3'd2, 32'h0,        32'h80000000, 0));
        tbl.push_back(mk(1, 0, 32'h13,   3'd0, 32'h0,        32'hFFFFFF80, 0));
        tbl.push_back(mk(1, 0, 32'h13,   3'd4, 32'h0,        32'h00000080, 0));
        tbl.push_back(mk(1, 0, 32'h11,   3'd1, 32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 1, 32'h12,   3'd2, 32'h12345678, 32'h0,        1));
        tbl.push_back(mk(1, 0, 32'h10,   3'd2, 32'h0,        32'h80000000, 0));
        tbl.push_back(mk(0, 1, 32'h14,   3'd2, 32'h11223344, 32'h0,        0));
        tbl.push_back(mk(0, 1, 32'h16,   3'd1, 32'hFFFFA5C3, 32'h0,        0));
        tbl.push_back(mk(1, 0, 32'h14,   3'd2, 32'h0,        32'hA5C33344, 0));
        tbl.push_back(mk(1, 0, 32'h16,   3'd1, 32'h0,        32'hFFFFA5C3, 0));
        tbl.push_back(mk(1, 0, 32'h16,   3'd5, 32'h0,        32'h0000A5C3, 0));
        tbl.push_back(mk(1, 0, 32'h14,   3'd0, 32'h0,        32'h00000044, 0));
        tbl.push_back(mk(1, 0, 32'h15,   3'd0, 32'h0,        32'h00000033, 0));
        tbl.push_back(mk(1, 0, 32'h14,   3'd3, 32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 1, 32'h14,   3'd4, 32'hFFFFFFFF, 32'h0,        1));
        tbl.push_back(mk(1, 1, 32'h14,   3'd2, 32'hFFFFFFFF, 32'h0,        1));
        tbl.push_back(mk(1, 0, 32'h14,   3'd2, 32'h0,        32'hA5C33344, 0));
        tbl.push_back(mk(1, 0, 32'h4010, 3'd2, 32'h0,        32'h80000000, 0));

        foreach (tbl[i]) begin
            run_op(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].f, tbl[i].d, gd, ge, lat, md, me);
            check($sformatf("tbl%0d_data", i), gd, tbl[i].exp_d);
            check($sformatf("tbl%0d_error", i), {31'h0, ge}, {31'h0, tbl[i].exp_e});
            check($sformatf("tbl%0d_latency", i), lat, 3);
        end

        // Both enables high is illegal; enables wiggled during WAIT must not start a request.
        @(negedge clk);
        rd_en[0] = 1; wr_en[0] = 1; addr = 32'h14; fmt = 3'd2; wdat = 32'h0;
        @(posedge clk);
        #1;
        rd_en[0] = 0; wr_en[0] = 0;
        @(negedge clk);
        check("busy_wait1", {31'h0, bsy[0]}, 32'h1);
        check("ready_wait1", {31'h0, rdy[0]}, 32'h0);
        rd_en[0] = 1; addr = 32'h10;
        @(negedge clk);
        check("busy_wait2", {31'h0, bsy[0]}, 32'h1);
        rd_en[0] = 0; wr_en[0] = 1;
        @(negedge clk);
        check("both_en_ready", {31'h0, rdy[0]}, 32'h1);
        check("both_en_error", {31'h0, err[0]}, 32'h1);
        check("both_en_data", rdata[0], 32'h0);
        wr_en[0] = 0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy[0]) extra++;
        end
        check("ignored_during_wait", extra, 0);

        // Reset one cycle after a store is accepted: outputs clear at once, store is dropped.
        @(negedge clk);
        wr_en[0] = 1; addr = 32'h10; fmt = 3'd2; wdat = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        wr_en[0] = 0;
        @(negedge clk);
        check("busy_before_reset", {31'h0, bsy[0]}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_reset_flags", {29'h0, rdy[0], bsy[0], err[0]}, 32'h0);
        check("async_reset_data", rdata[0], 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1, 0, 32'h10, 3'd2, 32'h0, gd, ge, lat, md, me);
        check("store_discarded", gd, 32'h80000000);

        // Back-to-back loads with read_enable held high.
        @(negedge clk);
        rd_en[0] = 1; addr = 32'h10; fmt = 3'd2;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (rdy[0]) t.push_back(c);
        end
        rd_en[0] = 0;
        repeat (8) @(negedge clk);
        if (t.size() < 3) begin
            checks++; failures++;
            $display("FAIL throughput_pulses actual=%0d required=3", t.size());
        end else begin
            check("throughput_first", t[0], 3);
            check("throughput_gap1", t[1] - t[0], 4);
            check("throughput_gap2", t[2] - t[1], 4);
        end

        // Randomized traffic over eight pre-initialised words with random alias bits.
        for (int w = 0; w < 8; w++) begin
            a = ($urandom() & 32'hFFFFF000) | (w << 2);
            run_op(0, 1, a, 3'd2, $urandom(), gd, ge, lat, md, me);
        end
        for (int k = 0; k < 60; k++) begin
            a  = ($urandom() & 32'hFFFFF000) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            f  = 3'($urandom_range(0, 7));
            rd = ($urandom_range(0, 1) == 1);
            wr = !rd;
            if ($urandom_range(0, 15) == 0) begin rd = 1; wr = 1; end
            run_op(rd, wr, a, f, $urandom(), gd, ge, lat, md, me);
            check($sformatf("rand%0d_data", k), gd, md);
            check($sformatf("rand%0d_error", k), {31'h0, ge}, {31'h0, me});
        end

        // Zero wait states and address wrap on the 16-word instance.
        do_req(1, 0, 1, 32'h8, 3'd2, 32'h0BADCAFE, gd, ge, lat);
        check("ws0_store_latency", lat, 1);
        check("ws0_store_error", {31'h0, ge}, 32'h0);
        do_req(1, 1, 0, 32'd72, 3'd2, 32'h0, gd, ge, lat);
        check("ws0_load_latency", lat, 1);
        check("ws0_alias_data", gd, 32'h0BADCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
